// File: rtl/key_entry_pkg.sv
// Shared key codes and FSM state encoding for the keypad entry controller.
package key_entry_pkg;

  localparam logic [3:0] KEY_NONE  = 4'hF;
  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_BKSP  = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hD;
  localparam logic [3:0] KEY_CLEAR = 4'hE;

  typedef enum logic [1:0] {S_OPA, S_OPB, S_DONE} state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/module_key_press_detect.sv
// Turns the scanner's intermittent sample stream into one strobe per key press.
// A key is locked out until RELEASE_CYCLES consecutive idle codes are seen.
module module_key_press_detect
  import key_entry_pkg::*;
#(
  parameter int RELEASE_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sample,
  output logic       accept,
  output logic       key_strobe,
  output logic [3:0] key_code
);

  localparam int CNT_W = (RELEASE_CYCLES > 2) ? $clog2(RELEASE_CYCLES) : 1;

  logic             lock;
  logic [CNT_W-1:0] release_cnt;

  // Combinational so the controller can act on the key at the accepting edge.
  assign accept = !lock && (sample != KEY_NONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      lock        <= 1'b0;
      release_cnt <= '0;
      key_strobe  <= 1'b0;
      key_code    <= '0;
    end else begin
      key_strobe <= 1'b0;
      if (accept) begin
        key_strobe  <= 1'b1;
        key_code    <= sample;
        lock        <= 1'b1;
        release_cnt <= '0;
      end else if (lock) begin
        if (sample != KEY_NONE) begin
          release_cnt <= '0;
        end else if (release_cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
          lock        <= 1'b0;
          release_cnt <= '0;
        end else begin
          release_cnt <= release_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/module_key_entry_ctrl.sv
// Collects debounced keypad events into two BCD operands plus an operator and
// hands them to the arithmetic datapath over a valid/ready handshake.
//
//   state  | meaning
//   S_OPA  | editing operand A
//   S_OPB  | editing operand B, operator may still be changed
//   S_DONE | transaction presented, waiting for out_ready
module module_key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int RELEASE_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   sample,
  output logic                         key_strobe,
  output logic [3:0]                   key_code,
  output logic [4*DIGITS-1:0]          entry_value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         entering_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          operand_a,
  output logic [4*DIGITS-1:0]          operand_b,
  output logic                         op_sub
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  state_t state;
  logic   accept;
  logic   clear_now;

  module_key_press_detect #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_press_detect (
    .clk       (clk),
    .reset     (reset),
    .sample    (sample),
    .accept    (accept),
    .key_strobe(key_strobe),
    .key_code  (key_code)
  );

  function automatic logic [BCD_W-1:0] push_digit(input logic [BCD_W-1:0] v,
                                                  input logic [3:0] d);
    return {v[BCD_W-5:0], d};
  endfunction

  function automatic logic [BCD_W-1:0] pop_digit(input logic [BCD_W-1:0] v);
    return {4'h0, v[BCD_W-1:4]};
  endfunction

  // Clear key and datapath acceptance land on the same action, so a
  // coincident pair cannot double-fire.
  assign clear_now = (accept && sample == KEY_CLEAR) || (state == S_DONE && out_ready);

  assign entering_b  = (state == S_OPB);
  assign entry_value = (state == S_OPA) ? operand_a : operand_b;

  always_ff @(posedge clk) begin
    if (reset || clear_now) begin
      state       <= S_OPA;
      operand_a   <= '0;
      operand_b   <= '0;
      op_sub      <= 1'b0;
      digit_count <= '0;
      out_valid   <= 1'b0;
    end else if (accept) begin
      case (state)
        S_OPA: begin
          if (is_digit(sample)) begin
            if (digit_count < CNT_W'(DIGITS)) begin
              operand_a   <= push_digit(operand_a, sample);
              digit_count <= digit_count + CNT_W'(1);
            end
          end else if (sample == KEY_BKSP) begin
            if (digit_count != '0) begin
              operand_a   <= pop_digit(operand_a);
              digit_count <= digit_count - CNT_W'(1);
            end
          end else if (sample == KEY_ADD || sample == KEY_SUB) begin
            op_sub      <= (sample == KEY_SUB);
            digit_count <= '0;
            state       <= S_OPB;
          end
        end
        S_OPB: begin
          if (is_digit(sample)) begin
            if (digit_count < CNT_W'(DIGITS)) begin
              operand_b   <= push_digit(operand_b, sample);
              digit_count <= digit_count + CNT_W'(1);
            end
          end else if (sample == KEY_BKSP) begin
            if (digit_count != '0) begin
              operand_b   <= pop_digit(operand_b);
              digit_count <= digit_count - CNT_W'(1);
            end
          end else if (sample == KEY_ADD || sample == KEY_SUB) begin
            op_sub <= (sample == KEY_SUB);
          end else if (sample == KEY_ENTER) begin
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: ;
        default: state <= S_OPA;
      endcase
    end
  end

endmodule
